// File: rtl/rv32i_pkg.sv
// Shared RV32I immediate-format encodings and packer control states.
// Also used by the decode-side sign extender and the control path.
package rv32i_pkg;

  typedef logic [1:0] imm_src_t;

  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } pack_state_e;

endpackage

// File: rtl/imm_instr_packer_if.sv
// Input stream from the loader: immediate, template and format over valid/ready.
interface imm_instr_packer_if;
  import rv32i_pkg::*;

  logic        in_valid;
  logic        in_ready;
  imm_src_t    in_imm_src;
  logic [31:0] in_imm;
  logic [31:0] in_tmpl;
  logic        in_last;

  modport master (
    output in_valid, in_imm_src, in_imm, in_tmpl, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_imm_src, in_imm, in_tmpl, in_last,
    output in_ready
  );

endinterface

// File: rtl/imm_pack.sv
// Combinational immediate packer: inverse of the decode sign extender, plus
// a check that the decoder would reproduce the immediate exactly.
module imm_pack
  import rv32i_pkg::*;
(
  input  imm_src_t    imm_src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] tmpl_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic fits12;
  logic fits13;

  // I/S decode from 12 bits, B from 13 bits with an implicit zero LSB.
  assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);

  always_comb begin
    word_o  = tmpl_i;
    legal_o = 1'b0;
    case (imm_src_i)
      IMM_I: begin
        word_o  = {imm_i[11:0], tmpl_i[19:0]};
        legal_o = fits12;
      end
      IMM_S: begin
        word_o  = {imm_i[11:5], tmpl_i[24:12], imm_i[4:0], tmpl_i[6:0]};
        legal_o = fits12;
      end
      IMM_B: begin
        word_o  = {imm_i[12], imm_i[10:5], tmpl_i[24:12], imm_i[4:1], imm_i[11], tmpl_i[6:0]};
        legal_o = fits13 && !imm_i[0];
      end
      default: begin
        word_o  = tmpl_i;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_instr_packer.sv
// Packs immediates into instruction templates and writes them sequentially
// into instruction memory; rejects immediates the decoder cannot reproduce.
module imm_instr_packer
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imm_instr_packer_if.slave   in_if,
  output logic                im_we,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [31:0]         im_wdata,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ADDR_W:0]     word_cnt
);

  localparam int CNT_W = ADDR_W + 1;

  pack_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              done_q, full_q, err_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic        in_ready;
  logic        accept;
  logic [31:0] packed_word;
  logic        legal;

  imm_pack u_pack (
    .imm_src_i (in_if.in_imm_src),
    .imm_i     (in_if.in_imm),
    .tmpl_i    (in_if.in_tmpl),
    .word_o    (packed_word),
    .legal_o   (legal)
  );

  assign accept = in_if.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // start wins over any accept in the same cycle; that word is dropped.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD && accept) begin
      if (!legal)                              state_d = ST_ERROR;
      else if (in_if.in_last || addr_q == '1)  state_d = ST_DONE;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_q == ST_LOAD) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      word_cnt_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      im_we_q <= 1'b0;
      if (start) begin
        addr_q     <= '0;
        word_cnt_q <= '0;
        done_q     <= 1'b0;
        full_q     <= 1'b0;
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end else if (accept) begin
        if (legal) begin
          im_we_q    <= 1'b1;
          im_addr_q  <= addr_q;
          im_wdata_q <= packed_word;
          addr_q     <= addr_q + ADDR_W'(1);
          word_cnt_q <= word_cnt_q + CNT_W'(1);
          if (in_if.in_last) begin
            done_q <= 1'b1;
          end else if (addr_q == '1) begin
            done_q <= 1'b1;
            full_q <= 1'b1;
          end
        end else begin
          err_q      <= 1'b1;
          err_addr_q <= addr_q;
        end
      end
    end
  end

  assign in_if.in_ready = in_ready;
  assign im_we          = im_we_q;
  assign im_addr        = im_addr_q;
  assign im_wdata       = im_wdata_q;
  assign done           = done_q;
  assign full           = full_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;
  assign word_cnt       = word_cnt_q;

endmodule

// File: tb/tb_imm_instr_packer.sv
// Directed bench: scoreboard of expected IM writes, checked by decoding the
// written word back to its immediate and by exact words for known vectors.
module tb_imm_instr_packer;
  import rv32i_pkg::*;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic [7:0]  addr;
    bit          has_exact;
    logic [31:0] exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;

  imm_instr_packer_if ifa ();
  imm_instr_packer_if ifb ();

  logic        we_a, busy_a, done_a, full_a, err_a;
  logic [7:0]  addr_a, err_addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;

  logic        we_b, busy_b, done_b, full_b, err_b;
  logic [1:0]  addr_b, err_addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_err = 0;

  imm_instr_packer #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_if(ifa),
    .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a), .busy(busy_a),
    .done(done_a), .full(full_a), .err(err_a), .err_addr(err_addr_a),
    .word_cnt(cnt_a)
  );

  imm_instr_packer #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_if(ifb),
    .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b), .busy(busy_b),
    .done(done_b), .full(full_b), .err(err_b), .err_addr(err_addr_b),
    .word_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decoder-side sign extension, written from the instruction format tables.
  function automatic logic [31:0] sext(input logic [1:0] src, input logic [31:0] w);
    case (src)
      IMM_I:   return {{20{w[31]}}, w[31:20]};
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      default: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [1:0] src);
    return (src == IMM_I) ? 32'h000F_FFFF : 32'h01FF_F07F;
  endfunction

  task automatic check_write(input string nm, input exp_t e, input logic [31:0] addr,
                             input logic [31:0] w);
    chk({nm, "_addr"}, addr, 32'(e.addr));
    chk({nm, "_decode"}, sext(e.src, w), e.imm);
    chk({nm, "_tmpl_bits"}, w & keep_mask(e.src), e.tmpl & keep_mask(e.src));
    if (e.has_exact) chk({nm, "_wdata"}, w, e.exact);
  endtask

  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      chk("wr_a_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) check_write("wr_a", qa.pop_front(), 32'(addr_a), wdata_a);
    end
    if (we_b === 1'b1) begin
      chk("wr_b_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) check_write("wr_b", qb.pop_front(), 32'(addr_b), wdata_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] tmpl, input logic last, input bit wr,
                      input logic [7:0] addr, input bit has_exact, input logic [31:0] exact);
    exp_t e;
    e = '{src: src, imm: imm, tmpl: tmpl, addr: addr, has_exact: has_exact, exact: exact};
    if (wr) begin
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    if (sel) begin
      ifb.in_valid = 1'b1; ifb.in_imm_src = src; ifb.in_imm = imm;
      ifb.in_tmpl = tmpl; ifb.in_last = last;
    end else begin
      ifa.in_valid = 1'b1; ifa.in_imm_src = src; ifa.in_imm = imm;
      ifa.in_tmpl = tmpl; ifa.in_last = last;
    end
    tick();
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic check_reset_a(input string nm);
    chk({nm, "_ready"},    32'(ifa.in_ready), 32'd0);
    chk({nm, "_we"},       32'(we_a), 32'd0);
    chk({nm, "_addr"},     32'(addr_a), 32'd0);
    chk({nm, "_wdata"},    wdata_a, 32'd0);
    chk({nm, "_busy"},     32'(busy_a), 32'd0);
    chk({nm, "_done"},     32'(done_a), 32'd0);
    chk({nm, "_full"},     32'(full_a), 32'd0);
    chk({nm, "_err"},      32'(err_a), 32'd0);
    chk({nm, "_err_addr"}, 32'(err_addr_a), 32'd0);
    chk({nm, "_cnt"},      32'(cnt_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_imm_src = IMM_I; ifa.in_imm = '0; ifa.in_tmpl = '0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_imm_src = IMM_I; ifb.in_imm = '0; ifb.in_tmpl = '0; ifb.in_last = 1'b0;
    tick(); tick();
    check_reset_a("rst");
    chk("rst_b_cnt", 32'(cnt_b), 32'd0);
    rst = 1'b0;
    tick();

    // Valid held with no start: nothing accepted.
    ifa.in_valid = 1'b1; ifa.in_imm_src = IMM_I; ifa.in_imm = 32'd1; ifa.in_tmpl = 32'h13;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(ifa.in_ready), 32'd0);
      tick();
    end
    ifa.in_valid = 1'b0;
    chk("bp_cnt", 32'(cnt_a), 32'd0);
    chk("bp_we", 32'(we_a), 32'd0);

    // Single I-type word with last.
    pulse_start(1'b0);
    chk("arm_busy", 32'(busy_a), 32'd1);
    chk("arm_ready", 32'(ifa.in_ready), 32'd1);
    send(1'b0, IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 1'b1, 8'd0, 1'b1, 32'hFFF0_0013);
    chk("i_we", 32'(we_a), 32'd1);
    chk("i_done", 32'(done_a), 32'd1);
    chk("i_cnt", 32'(cnt_a), 32'd1);
    chk("i_busy", 32'(busy_a), 32'd0);
    tick();
    chk("i_we_drop", 32'(we_a), 32'd0);
    chk("i_done_sticky", 32'(done_a), 32'd1);

    // S and B packing, I boundary, then out-of-range I at addr 3.
    pulse_start(1'b0);
    chk("restart_done_clr", 32'(done_a), 32'd0);
    send(1'b0, IMM_S, 32'h0000_07E4, 32'h0000_2023, 1'b0, 1'b1, 8'd0, 1'b1, 32'h7E00_2223);
    send(1'b0, IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 1'b0, 1'b1, 8'd1, 1'b1, 32'hFE00_0EE3);
    send(1'b0, IMM_I, 32'd2047, 32'h00A0_0093, 1'b0, 1'b1, 8'd2, 1'b0, 32'd0);
    send(1'b0, IMM_I, 32'd2048, 32'h0000_0093, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("rng_err", 32'(err_a), 32'd1);
    chk("rng_err_addr", 32'(err_addr_a), 32'd3);
    chk("rng_ready", 32'(ifa.in_ready), 32'd0);
    chk("rng_we", 32'(we_a), 32'd0);
    chk("rng_cnt", 32'(cnt_a), 32'd3);
    chk("rng_done", 32'(done_a), 32'd0);
    send(1'b0, IMM_I, 32'd5, 32'h13, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("err_hold_cnt", 32'(cnt_a), 32'd3);
    pulse_start(1'b0);
    chk("clr_err", 32'(err_a), 32'd0);
    chk("clr_ready", 32'(ifa.in_ready), 32'd1);
    chk("clr_cnt", 32'(cnt_a), 32'd0);

    // B: even offset legal, odd offset with last rejected.
    send(1'b0, IMM_B, 32'd6, 32'h00B5_0063, 1'b0, 1'b1, 8'd0, 1'b0, 32'd0);
    send(1'b0, IMM_B, 32'd5, 32'h00B5_0063, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("bodd_err", 32'(err_a), 32'd1);
    chk("bodd_err_addr", 32'(err_addr_a), 32'd1);
    chk("bodd_done", 32'(done_a), 32'd0);
    chk("bodd_cnt", 32'(cnt_a), 32'd1);

    pulse_start(1'b0);
    send(1'b0, 2'b11, 32'd0, 32'h13, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("src11_err", 32'(err_a), 32'd1);
    chk("src11_err_addr", 32'(err_addr_a), 32'd0);

    pulse_start(1'b0);
    send(1'b0, IMM_I, 32'hFFFF_F800, 32'h0010_8093, 1'b0, 1'b1, 8'd0, 1'b0, 32'd0);
    send(1'b0, IMM_I, 32'hFFFF_F7FF, 32'h0010_8093, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("ineg_err_addr", 32'(err_addr_a), 32'd1);

    pulse_start(1'b0);
    send(1'b0, IMM_B, 32'hFFFF_F000, 32'h0020_9063, 1'b0, 1'b1, 8'd0, 1'b0, 32'd0);
    send(1'b0, IMM_S, 32'hFFFF_F801, 32'h0020_A023, 1'b0, 1'b1, 8'd1, 1'b0, 32'd0);
    send(1'b0, IMM_B, 32'd4096, 32'h0020_9063, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("bbig_err", 32'(err_a), 32'd1);
    chk("bbig_err_addr", 32'(err_addr_a), 32'd2);

    // start beats an accept in the same cycle.
    pulse_start(1'b0);
    send(1'b0, IMM_I, 32'd1, 32'h13, 1'b0, 1'b1, 8'd0, 1'b0, 32'd0);
    start_a = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_imm_src = IMM_I; ifa.in_imm = 32'd7; ifa.in_last = 1'b0;
    tick();
    start_a = 1'b0; ifa.in_valid = 1'b0;
    chk("prio_cnt", 32'(cnt_a), 32'd0);
    chk("prio_we", 32'(we_a), 32'd0);
    chk("prio_busy", 32'(busy_a), 32'd1);
    send(1'b0, IMM_I, 32'd9, 32'h13, 1'b1, 1'b1, 8'd0, 1'b0, 32'd0);
    tick();
    chk("drain_a1", 32'(qa.size()), 32'd0);

    // Reset the cycle after an accept; the held second word is not taken.
    pulse_start(1'b0);
    qa.push_back('{src: IMM_I, imm: 32'd3, tmpl: 32'h13, addr: 8'd0, has_exact: 1'b0, exact: 32'd0});
    ifa.in_valid = 1'b1; ifa.in_imm_src = IMM_I; ifa.in_imm = 32'd3; ifa.in_tmpl = 32'h13; ifa.in_last = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ifa.in_valid = 1'b0;
    check_reset_a("midrst");
    tick();
    chk("drain_a2", 32'(qa.size()), 32'd0);

    // Fill a 4-word IM without last.
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++)
      send(1'b1, IMM_I, 32'(i * 16 - 8), 32'h0000_0013 | (32'(i) << 7), 1'b0, 1'b1,
           8'(i), 1'b0, 32'd0);
    chk("full_full", 32'(full_b), 32'd1);
    chk("full_done", 32'(done_b), 32'd1);
    chk("full_cnt", 32'(cnt_b), 32'd4);
    chk("full_we", 32'(we_b), 32'd1);
    send(1'b1, IMM_I, 32'd1, 32'h13, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    chk("full_no5_we", 32'(we_b), 32'd0);
    chk("full_no5_cnt", 32'(cnt_b), 32'd4);
    tick();
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
